// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Handshake bundle between an instruction producer (program loader / bench)
//   and the instruction encoder.
//
//   Field side  : in_valid/in_ready plus the decoded fields
//                 kind (00=R, 01=LW, 10=SW, 11=BEQ), rs, rt, rd, shamt,
//                 funct, imm.
//   Word side   : out_valid/out_ready plus the encoded 32-bit instr and
//                 its ADDR_W-bit word address.
//
//   master : producer of field bundles and consumer of encoded words.
//   slave  : the encoder itself.
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        kind;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;

    modport master (
        output in_valid, kind, rs, rt, rd, shamt, funct, imm, out_ready,
        input  in_ready, out_valid, instr, addr
    );

    modport slave (
        input  in_valid, kind, rs, rt, rd, shamt, funct, imm, out_ready,
        output in_ready, out_valid, instr, addr
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs decoded MIPS-subset fields (R-type, LW, SW, BEQ) into 32-bit
//   instruction words and streams them, with a sequential word address,
//   towards an instruction-memory write port. Intake stops once MAX_WORDS
//   words have been accepted since reset/clear.
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-low reset
//     clear  - synchronous restart: zero address/count, drop output word
//     bus    - instr_encoder_if.slave (field bundle in, encoded word out)
//     count  - words accepted since reset/clear (ADDR_W+1 bits)
//     full   - count == MAX_WORDS
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    typedef enum logic [1:0] {
        KIND_R   = 2'b00,
        KIND_LW  = 2'b01,
        KIND_SW  = 2'b10,
        KIND_BEQ = 2'b11
    } kind_e;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    logic              out_valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;

    kind_e             kind;
    logic [31:0]       enc_word;
    logic              in_ready;
    logic              accept;
    logic              xfer;

    assign kind = kind_e'(bus.kind);

    always_comb begin
        enc_word = '0;
        unique case (kind)
            KIND_R:   enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            KIND_LW:  enc_word = {6'b100011, bus.rs, bus.rt, bus.imm};
            KIND_SW:  enc_word = {6'b101011, bus.rs, bus.rt, bus.imm};
            KIND_BEQ: enc_word = {6'b000100, bus.rs, bus.rt, bus.imm};
        endcase
    end

    // The output register can take a new word when it is empty or is being
    // drained this same cycle; clear blocks intake so the restarted load
    // begins cleanly at address 0.
    always_comb begin
        full     = (count_q == MAX_CNT);
        in_ready = !clear && !full && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
        xfer     = out_valid_q && bus.out_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            addr_q      <= '0;
            count_q     <= '0;
        end else if (clear) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            addr_q      <= '0;
            count_q     <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                instr_q     <= enc_word;
                addr_q      <= count_q[ADDR_W-1:0];
                count_q     <= count_q + 1'b1;
            end else if (xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.instr     = instr_q;
    assign bus.addr      = addr_q;
    assign count         = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder. The DUT is built with ADDR_W=2 and
//   MAX_WORDS=4 so that the full limit coincides with 2^ADDR_W, exercising
//   the last-address (3) and count==4 corner without address wrap.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int ADDR_W    = 2;
    localparam int MAX_WORDS = 4;

    logic            clk;
    logic            reset;
    logic            clear;
    logic [ADDR_W:0] count;
    logic            full;

    int vectors;
    int miscompares;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus),
        .count (count),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [5:0] fn);
        bus.kind  = 2'b00;
        bus.rs    = rs;
        bus.rt    = rt;
        bus.rd    = rd;
        bus.shamt = sh;
        bus.funct = fn;
        bus.imm   = 16'h0000;
    endtask

    task automatic set_i(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm);
        bus.kind = k;
        bus.rs   = rs;
        bus.rt   = rt;
        bus.imm  = imm;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        reset         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.kind      = 2'b00;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.rd        = '0;
        bus.shamt     = '0;
        bus.funct     = '0;
        bus.imm       = '0;

        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_instr",     bus.instr,          32'h0);
        chk("rst_addr",      32'(bus.addr),      32'd0);
        chk("rst_count",     32'(count),         32'd0);
        chk("rst_full",      32'(full),          32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // R-type add r3, r1, r2
        set_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("r_valid", 32'(bus.out_valid), 32'd1);
        chk("r_instr", bus.instr,          32'h00221820);
        chk("r_addr",  32'(bus.addr),      32'd0);
        chk("r_count", 32'(count),         32'd1);
        step();
        chk("r_drain_valid", 32'(bus.out_valid), 32'd0);

        // LW, SW, BEQ back-to-back; rd/shamt/funct are junk and must be ignored
        do_clear();
        chk("clr_count", 32'(count), 32'd0);
        bus.rd = 5'd3; bus.shamt = 5'd7; bus.funct = 6'h3F;
        set_i(2'b01, 5'd4, 5'd5, 16'h0010);
        bus.in_valid = 1'b1;
        step();
        chk("lw_instr", bus.instr,     32'h8C850010);
        chk("lw_addr",  32'(bus.addr), 32'd0);
        set_i(2'b10, 5'd4, 5'd5, 16'h0010);
        step();
        chk("sw_instr", bus.instr,     32'hAC850010);
        chk("sw_addr",  32'(bus.addr), 32'd1);
        chk("sw_valid", 32'(bus.out_valid), 32'd1);
        set_i(2'b11, 5'd4, 5'd5, 16'hFFFE);
        step();
        bus.in_valid = 1'b0;
        chk("beq_instr", bus.instr,     32'h1085FFFE);
        chk("beq_addr",  32'(bus.addr), 32'd2);
        step();
        chk("b2b_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("b2b_count",       32'(count),         32'd3);

        // Stall: one word held for 3 cycles with a second bundle waiting
        do_clear();
        bus.out_ready = 1'b0;
        set_r(5'd31, 5'd0, 5'd17, 5'd5, 6'h2A);
        bus.in_valid = 1'b1;
        step();
        set_i(2'b01, 5'd2, 5'd3, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid",    32'(bus.out_valid), 32'd1);
            chk("stall_instr",    bus.instr,          32'h03E0896A);
            chk("stall_addr",     32'(bus.addr),      32'd0);
            chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("release_valid", 32'(bus.out_valid), 32'd1);
        chk("release_instr", bus.instr,          32'h8C431234);
        chk("release_addr",  32'(bus.addr),      32'd1);
        chk("release_count", 32'(count),         32'd2);
        step();
        chk("release_drain", 32'(bus.out_valid), 32'd0);

        // Full at MAX_WORDS=4: fifth bundle must be held off
        do_clear();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_r(5'd0, 5'd0, 5'd0, 5'd0, 6'(i));
            step();
            chk("fill_addr",  32'(bus.addr), 32'(i));
            chk("fill_instr", bus.instr,     32'(i));
        end
        set_r(5'd0, 5'd0, 5'd0, 5'd0, 6'd4);
        chk("full_flag",     32'(full),         32'd1);
        chk("full_count",    32'(count),        32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("full_last_drain", 32'(bus.out_valid), 32'd0);
        chk("full_hold_count", 32'(count),         32'd4);
        step();
        chk("full_hold_count2", 32'(count), 32'd4);
        chk("full_hold_flag",   32'(full),  32'd1);
        clear = 1'b1;
        #1;
        chk("clear_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        clear = 1'b0;
        #1;
        chk("clear_full",     32'(full),         32'd0);
        chk("clear_count",    32'(count),        32'd0);
        chk("clear_in_ready2",32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("after_clear_addr",  32'(bus.addr), 32'd0);
        chk("after_clear_instr", bus.instr,     32'h00000004);
        step();

        // Asynchronous reset during a stall
        bus.out_ready = 1'b0;
        set_i(2'b10, 5'd7, 5'd8, 16'h00AA);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_count", 32'(count),         32'd0);
        chk("async_rst_instr", bus.instr,          32'h0);
        step();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
        set_i(2'b11, 5'd1, 5'd1, 16'h0003);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_addr",  32'(bus.addr), 32'd0);
        chk("post_rst_instr", bus.instr,     32'h10210003);

        // Clear in the same cycle as a valid bundle
        set_r(5'd9, 5'd10, 5'd11, 5'd1, 6'h22);
        bus.in_valid = 1'b1;
        clear = 1'b1;
        #1;
        chk("clr_in_ready_same", 32'(bus.in_ready), 32'd0);
        step();
        clear = 1'b0;
        chk("clr_same_count", 32'(count),         32'd0);
        chk("clr_same_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("clr_next_addr",  32'(bus.addr), 32'd0);
        chk("clr_next_count", 32'(count),    32'd1);
        chk("clr_next_instr", bus.instr,     32'h012A5862);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Builds 32-bit MIPS-subset instruction words (R-type, LW, SW, BEQ) from decoded fields. It is the inverse of the control decoder path.
- Streams the words through a valid/ready handshake to the instruction-memory write port, along with a sequential word address.
- Used by the program loader and by self-checking benches to generate the opcodes the datapath controller consumes.
- A word limit stops intake once the target memory is full.

Parameters:
ADDR_W, 8, width of the output word address and counter.
MAX_WORDS, 256, number of words accepted before `full` asserts (1..2^ADDR_W).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
clear  input  1  synchronous: zero address/count, drop the output register, deassert full.
in_valid  input  1  field bundle valid.
in_ready  output  1  encoder can accept the bundle this cycle.
kind  input  2  00=R-type, 01=LW, 10=SW, 11=BEQ.
rs  input  5  source register.
rt  input  5  target register.
rd  input  5  destination register (R-type only).
shamt  input  5  shift amount (R-type only).
funct  input  6  function code (R-type only).
imm  input  16  immediate / branch offset (I-type only).
out_valid  output  1  instr/addr valid.
out_ready  input  1  downstream accepts the word.
instr  output  32  encoded instruction.
addr  output  ADDR_W  word address of instr.
count  output  ADDR_W+1  words accepted since reset/clear.
full  output  1  count == MAX_WORDS.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, instr=0, addr=0, count=0, full=0. All state clears immediately, including any word in flight. Nothing is emitted after release until a new in_valid.
- Handshake rules:
  - in_ready = !full && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: an accepted bundle appears registered on instr/addr with out_valid=1 the next cycle. Back-to-back acceptance gives full throughput (one word per cycle while out_ready=1).
- Stall: while out_valid && !out_ready, instr, addr and out_valid hold stable, and in_ready=0.
- Encoding, by kind:
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - LW: {6'b100011, rs, rt, imm}.
  - SW: {6'b101011, rs, rt, imm}.
  - BEQ: {6'b000100, rs, rt, imm}.
  - I-type kinds ignore rd/shamt/funct.
- Address and count:
  - addr of an accepted word = current count[ADDR_W-1:0].
  - count increments by 1 on each acceptance.
  - If MAX_WORDS=2^ADDR_W, the last word gets addr=2^ADDR_W-1. count reaches 2^ADDR_W and addr never wraps within one load.
- Full:
  - full asserts the cycle after the acceptance that makes count==MAX_WORDS.
  - While full, in_ready=0. The final word still completes its output transfer normally.
- Output register update, when out_valid=1:
  - Transfer without a new accept: out_valid goes to 0.
  - Transfer with a simultaneous accept: the register is replaced by the new word and out_valid stays 1.
- clear:
  - count=0, full=0, out_valid=0 next cycle.
  - A bundle presented in the same cycle is not accepted (in_ready forced 0 while clear=1).
- Reset asserted mid-stall: the pending word is lost, and out_valid drops asynchronously.

Test Plan:
- R-type: kind=00, rs=1, rt=2, rd=3, shamt=0, funct=6'h20, out_ready=1 -> next cycle instr=32'h00221820, addr=0, count=1.
- LW, SW, BEQ back-to-back:
  - Stimulus: three bundles with rs=4, rt=5, imm=16'h0010, then 16'h0010, then 16'hFFFE.
  - Required: instr=32'h8C850010, 32'hAC850010, 32'h1085FFFE on consecutive cycles, addr=0,1,2.
- Stall: hold out_ready=0 for 3 cycles after one accept -> instr/addr stable, in_ready=0. Release -> transfer; a new bundle accepted in the release cycle appears the next cycle.
- Full with MAX_WORDS=4:
  - Stimulus: send 5 bundles.
  - Required: first 4 accepted (addr 0..3), full=1 after the 4th, in_ready=0, 5th bundle held. clear -> full=0, count=0, next word addr=0.
- Reset mid-operation: drop reset while out_valid=1 and out_ready=0 -> out_valid=0 immediately, count=0. After release, first word gets addr=0.
- Simultaneous clear and in_valid: bundle not accepted, count=0. Same bundle accepted the next cycle with addr=0.
